lcd_ctrl: RTL and testbench

- Downstream consumer of the core's LCD memory-mapped output. Turns byte writes from the LSU into HD44780-compatible parallel bus cycles.
- Runs the power-on initialisation sequence on its own.
- Buffers core writes in a small FIFO, so a store completes in one cycle while the slow LCD bus timing runs in the background.
- Reports busy and overflow status that the LSU can map back as read data.

---
 rtl/lcd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 parallel-bus controller: buffers LSU byte writes in a small FIFO and
// replays them as timed RS/DATA/EN bus cycles after a built-in init sequence.
module lcd_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 3,
  parameter int unsigned T_EN_CYC    = 25,
  parameter int unsigned T_CMD_CYC   = 2000,
  parameter int unsigned T_CLR_CYC   = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_word,
  output logic        o_lcd_ready,
  output logic        o_lcd_busy,
  output logic        o_lcd_ovf,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned T_MAX_0 = (T_PWRUP_CYC > T_CLR_CYC) ? T_PWRUP_CYC : T_CLR_CYC;
  localparam int unsigned T_MAX_1 = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
  localparam int unsigned T_MAX_2 = (T_MAX_1 > T_SETUP_CYC) ? T_MAX_1 : T_SETUP_CYC;
  localparam int unsigned T_MAX   = (T_MAX_0 > T_MAX_2) ? T_MAX_0 : T_MAX_2;
  localparam int unsigned CW      = $clog2(T_MAX + 1);

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EN,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, wait_last;
  lcd_cmd_t      bus, bus_d, wr_cmd;
  logic [1:0]    init_idx, init_idx_d;
  logic          init_done, init_done_d;
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic          full, empty, push, pop, is_clr, busy_d;
  lcd_cmd_t      mem [FIFO_DEPTH];
  logic          unused_word_bits;

  function automatic lcd_cmd_t init_cmd(input logic [1:0] idx);
    lcd_cmd_t c;
    c.rs = 1'b0;
    case (idx)
      2'd0:    c.data = 8'h38;
      2'd1:    c.data = 8'h0C;
      2'd2:    c.data = 8'h01;
      default: c.data = 8'h06;
    endcase
    return c;
  endfunction

  // FIFO status: full is judged on the pre-edge pointers, so a pop never frees room for a same-edge push
  assign wr_cmd           = lcd_cmd_t'(i_lcd_word[8:0]);
  assign unused_word_bits = &{1'b0, i_lcd_word[31:9]};
  assign empty            = (wr_ptr == rd_ptr);
  assign full             = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push             = i_lcd_wr & ~full;
  assign pop              = (state == S_IDLE) & ~empty;
  assign wr_ptr_d         = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_d         = rd_ptr + {{AW{1'b0}}, pop};

  assign o_lcd_ready = ~full;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = bus.data;
  assign o_lcd_rs    = bus.rs;

  // Clear/home commands need the long post-EN wait
  assign is_clr    = ~bus.rs && (bus.data == 8'h01 || bus.data == 8'h02 || bus.data == 8'h03);
  assign wait_last = is_clr ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

  // Next-state logic: each state counts its own dwell, counter reloads on every entry
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + CW'(1);
    bus_d       = bus;
    init_idx_d  = init_idx;
    init_done_d = init_done;
    case (state)
      S_PWRUP: begin
        if (cnt == CW'(T_PWRUP_CYC - 1)) begin
          state_d    = S_SETUP;
          cnt_d      = '0;
          init_idx_d = 2'd0;
          bus_d      = init_cmd(2'd0);
        end
      end
      S_SETUP: begin
        if (cnt == CW'(T_SETUP_CYC - 1)) begin
          state_d = S_EN;
          cnt_d   = '0;
        end
      end
      S_EN: begin
        if (cnt == CW'(T_EN_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == wait_last) begin
          cnt_d = '0;
          if (!init_done && init_idx != 2'd3) begin
            init_idx_d = init_idx + 2'd1;
            bus_d      = init_cmd(init_idx + 2'd1);
            state_d    = S_SETUP;
          end else begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          bus_d   = mem[rd_ptr[AW-1:0]];
          state_d = S_SETUP;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE) | ~init_done_d | (wr_ptr_d != rd_ptr_d);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_PWRUP;
      cnt        <= '0;
      bus        <= '0;
      init_idx   <= 2'd0;
      init_done  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_lcd_en   <= 1'b0;
      o_lcd_busy <= 1'b1;
      o_lcd_ovf  <= 1'b0;
      o_lcd_on   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bus        <= bus_d;
      init_idx   <= init_idx_d;
      init_done  <= init_done_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      o_lcd_en   <= (state_d == S_EN);
      o_lcd_busy <= busy_d;
      o_lcd_ovf  <= o_lcd_ovf | (i_lcd_wr & full);
      o_lcd_on   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: a monitor logs every EN pulse, scenario
// tasks pop the logged pulses against a scoreboard of expected RS/DATA words.
module tb_lcd_ctrl;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;

  typedef struct {
    int         rise;
    int         fall;
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] word = '0;
  logic        ready, busy, ovf, rs, rw, en, on;
  logic [7:0]  data;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rd_idx = 0;
  int          rel = 0;
  logic [8:0]  exp_q[$];
  pulse_t      obs_q[$];
  pulse_t      cur;
  logic        en_q = 1'b0;

  lcd_ctrl #(
    .FIFO_DEPTH (4),
    .T_PWRUP_CYC(20),
    .T_SETUP_CYC(2),
    .T_EN_CYC   (4),
    .T_CMD_CYC  (10),
    .T_CLR_CYC  (30)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_lcd_wr   (wr),
    .i_lcd_word (word),
    .o_lcd_ready(ready),
    .o_lcd_busy (busy),
    .o_lcd_ovf  (ovf),
    .o_lcd_data (data),
    .o_lcd_rs   (rs),
    .o_lcd_rw   (rw),
    .o_lcd_en   (en),
    .o_lcd_on   (on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor; a pulse cut short by reset is never logged
  always @(negedge clk) begin
    if (!rst_n) begin
      en_q = 1'b0;
    end else begin
      if (en && !en_q) begin
        cur.rise = cyc;
        cur.rs   = rs;
        cur.data = data;
      end
      if (!en && en_q) begin
        cur.fall = cyc;
        obs_q.push_back(cur);
      end
      en_q = en;
    end
  end

  task automatic next_pulse(output pulse_t p, output bit ok);
    int k = 0;
    while (obs_q.size() <= rd_idx && k < 400) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() > rd_idx);
    p  = '{default: 0};
    if (ok) begin
      p = obs_q[rd_idx];
      rd_idx++;
    end
  endtask

  task automatic release_reset();
    rst_n  = 1'b1;
    rel    = cyc;
    rd_idx = obs_q.size();
    exp_q.delete();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (en !== 1'b0)    begin n_err++; $display("FAIL reset_en: got %b want 0", en); end
    n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (on !== 1'b0)    begin n_err++; $display("FAIL reset_on: got %b want 0", on); end
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
    n_cmp++; if (rs !== 1'b0)    begin n_err++; $display("FAIL reset_rs: got %b want 0", rs); end
    n_cmp++; if (rw !== 1'b0)    begin n_err++; $display("FAIL reset_rw: got %b want 0", rw); end
    release_reset();
    @(negedge clk);
    n_cmp++; if (on !== 1'b1)    begin n_err++; $display("FAIL on_after_release: got %b want 1", on); end
  endtask

  task automatic test_init();
    pulse_t pl[4];
    bit ok;
    logic [8:0] e;
    int k;
    for (int i = 0; i < 4; i++) begin
      next_pulse(pl[i], ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL init_pulse%0d: no EN pulse within bound", i);
      end else begin
        e = exp_q.pop_front();
        if ({pl[i].rs, pl[i].data} !== e) begin
          n_err++; $display("FAIL init_cmd%0d: got %h want %h", i, {pl[i].rs, pl[i].data}, e);
        end
        n_cmp++;
        if (pl[i].fall - pl[i].rise !== T_EN) begin
          n_err++; $display("FAIL init_width%0d: got %0d want %0d", i, pl[i].fall - pl[i].rise, T_EN);
        end
      end
    end
    n_cmp++;
    if (pl[0].rise - rel !== 22) begin
      n_err++; $display("FAIL init_first_en: got %0d want 22", pl[0].rise - rel);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (pl[i+1].rise - pl[i].fall !== ((i == 2) ? T_CLR + T_SETUP : T_CMD + T_SETUP)) begin
        n_err++; $display("FAIL init_gap%0d: got %0d want %0d", i, pl[i+1].rise - pl[i].fall,
                          (i == 2) ? T_CLR + T_SETUP : T_CMD + T_SETUP);
      end
    end
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (busy !== 1'b0 || cyc !== pl[3].fall + T_CMD) begin
      n_err++; $display("FAIL init_busy_fall: busy=%b at %0d want 0 at %0d", busy, cyc, pl[3].fall + T_CMD);
    end
    n_cmp++; if (on !== 1'b1) begin n_err++; $display("FAIL init_on: got %b want 1", on); end
  endtask

  task automatic test_single_write();
    pulse_t p;
    bit ok;
    int w, k;
    logic [8:0] e;
    w = cyc + 1;
    exp_q.push_back(9'h141);
    wr = 1'b1; word = 32'h0000_0141;
    @(negedge clk);
    wr = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (cyc - w !== 17) begin n_err++; $display("FAIL single_busy_len: got %0d want 17", cyc - w); end
    next_pulse(p, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL single_pulse: no EN pulse within bound");
    end else begin
      e = exp_q.pop_front();
      if ({p.rs, p.data} !== e) begin n_err++; $display("FAIL single_cmd: got %h want %h", {p.rs, p.data}, e); end
      n_cmp++;
      if (p.rise - w !== 1 + T_SETUP) begin n_err++; $display("FAIL single_en_rise: got %0d want 3", p.rise - w); end
      n_cmp++;
      if (p.fall - p.rise !== T_EN) begin n_err++; $display("FAIL single_width: got %0d want 4", p.fall - p.rise); end
    end
  endtask

  task automatic test_overflow();
    pulse_t p;
    bit ok;
    logic [8:0] e;
    rst_n = 1'b0;
    @(negedge clk);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; word = 32'h0000_0151 + 32'(i);
      if (i < 4) exp_q.push_back(9'h151 + 9'(i));
      @(negedge clk);
      if (i == 3) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready_full: got %b want 0", ready); end
        n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf); end
      end
    end
    wr = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
    for (int i = 0; i < 8; i++) begin
      next_pulse(p, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL ovf_pulse%0d: no EN pulse within bound", i);
      end else begin
        e = exp_q.pop_front();
        if ({p.rs, p.data} !== e) begin n_err++; $display("FAIL ovf_cmd%0d: got %h want %h", i, {p.rs, p.data}, e); end
      end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_clear_spacing();
    pulse_t p0, p1;
    bit ok0, ok1;
    logic [8:0] e;
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h142);
    wr = 1'b1; word = 32'h0000_0001;
    @(negedge clk);
    word = 32'h0000_0142;
    @(negedge clk);
    wr = 1'b0;
    next_pulse(p0, ok0);
    next_pulse(p1, ok1);
    n_cmp++;
    if (!ok0 || !ok1) begin
      n_err++; $display("FAIL clr_pulses: got %0d pulses want 2", int'(ok0) + int'(ok1));
    end else begin
      e = exp_q.pop_front();
      if ({p0.rs, p0.data} !== e) begin n_err++; $display("FAIL clr_cmd: got %h want %h", {p0.rs, p0.data}, e); end
      n_cmp++;
      e = exp_q.pop_front();
      if ({p1.rs, p1.data} !== e) begin n_err++; $display("FAIL clr_next_cmd: got %h want %h", {p1.rs, p1.data}, e); end
      n_cmp++;
      if (p1.rise - p0.fall !== T_CLR + 1 + T_SETUP) begin
        n_err++; $display("FAIL clr_spacing: got %0d want %0d", p1.rise - p0.fall, T_CLR + 1 + T_SETUP);
      end
    end
  endtask

  task automatic test_reset_mid_en();
    pulse_t p;
    bit ok;
    logic [8:0] e;
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    wr = 1'b1; word = 32'h0000_0143;
    @(negedge clk);
    word = 32'h0000_0144;
    @(negedge clk);
    wr = 1'b0;
    k = 0;
    while (!en && k < 50) begin @(negedge clk); k++; end
    n_cmp++; if (en !== 1'b1) begin n_err++; $display("FAIL mid_en_reach: got %b want 1", en); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (en !== 1'b0)    begin n_err++; $display("FAIL mid_en_drop: got %b want 0", en); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL mid_ovf_clear: got %b want 0", ovf); end
    n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", ready); end
    @(negedge clk);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      next_pulse(p, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL mid_init%0d: no EN pulse within bound", i);
      end else begin
        e = exp_q.pop_front();
        if ({p.rs, p.data} !== e) begin n_err++; $display("FAIL mid_init_cmd%0d: got %h want %h", i, {p.rs, p.data}, e); end
      end
    end
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || obs_q.size() !== rd_idx) begin
      n_err++; $display("FAIL mid_no_stale: busy=%b extra_pulses=%0d want 0/0", busy, obs_q.size() - rd_idx);
    end
  endtask

  task automatic test_full_pop_edge();
    pulse_t p;
    bit ok;
    logic [8:0] e;
    int w;
    w = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; word = 32'h0000_0161 + 32'(i);
      exp_q.push_back(9'h161 + 9'(i));
      @(negedge clk);
    end
    wr = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL fpe_full: got %b want 0", ready); end
    while (cyc < w + 17) @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL fpe_still_full: got %b want 0", ready); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL fpe_ovf_pre: got %b want 0", ovf); end
    wr = 1'b1; word = 32'h0000_0166;
    @(negedge clk);
    n_cmp++; if (ovf !== 1'b1)   begin n_err++; $display("FAIL fpe_ovf_set: got %b want 1", ovf); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL fpe_count3: got %b want 1", ready); end
    word = 32'h0000_0167;
    exp_q.push_back(9'h167);
    @(negedge clk);
    wr = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL fpe_refill: got %b want 0", ready); end
    for (int i = 0; i < 6; i++) begin
      next_pulse(p, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL fpe_pulse%0d: no EN pulse within bound", i);
      end else begin
        e = exp_q.pop_front();
        if ({p.rs, p.data} !== e) begin n_err++; $display("FAIL fpe_cmd%0d: got %h want %h", i, {p.rs, p.data}, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_overflow();
    test_clear_spacing();
    test_reset_mid_en();
    test_full_pop_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
